// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings for the multiply/divide unit.
// Op codes, FSM states and default latencies.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_NOP   = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6,
    MDU_RSVD  = 3'd7
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF  = 10;

  function automatic int mdu_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational 32x32 multiply and divide.
// Produces {hi,lo} and a divide-by-zero flag.
module mdu_arith
  import mdu_pkg::*;
(
  input  mdu_op_e     i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [63:0] o_res,
  output logic        o_dz
);

  logic [63:0]        w_sa;
  logic [63:0]        w_sb;
  logic [63:0]        w_ua;
  logic [63:0]        w_ub;
  logic signed [31:0] w_as;
  logic signed [31:0] w_bs;
  logic               w_bzero;
  logic               w_ovf;

  assign w_sa    = {{32{i_a[31]}}, i_a};
  assign w_sb    = {{32{i_b[31]}}, i_b};
  assign w_ua    = {32'h0, i_a};
  assign w_ub    = {32'h0, i_b};
  assign w_as    = i_a;
  assign w_bs    = i_b;
  assign w_bzero = (i_b == 32'h0);
  // most-negative / -1 overflows a 32-bit quotient
  assign w_ovf   = (i_a == 32'h8000_0000) &&
                   (i_b == 32'hFFFF_FFFF);

  // select the result for the requested operation
  always_comb begin
    o_res = 64'h0;
    o_dz  = 1'b0;
    case (i_op)
      MDU_MULT:  o_res = w_sa * w_sb;
      MDU_MULTU: o_res = w_ua * w_ub;
      MDU_DIV: begin
        if (w_bzero) begin
          o_dz = 1'b1;
        end else if (w_ovf) begin
          o_res = {32'h0, 32'h8000_0000};
        end else begin
          o_res[63:32] = w_as % w_bs;
          o_res[31:0]  = w_as / w_bs;
        end
      end
      MDU_DIVU: begin
        if (w_bzero) begin
          o_dz = 1'b1;
        end else begin
          o_res[63:32] = i_a % i_b;
          o_res[31:0]  = i_a / i_b;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: HI/LO multiply/divide unit with busy counter.
// Define MDU_DISPLAY_EN to print every HI/LO write.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mduStart,
  input  logic [2:0]  mduOp,
  input  logic [31:0] mduA,
  input  logic [31:0] mduB,
  input  logic        mduReadHi,
  output logic [31:0] mduRD,
  output logic        mduBusy,
  output logic        mduDone,
  input  logic [31:0] pc
);

  localparam int CNT_MAX = mdu_max(MULT_CYCLES, DIV_CYCLES);
  localparam int CW      = $clog2(CNT_MAX + 1);

  mdu_state_e  r_state;
  mdu_state_e  w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_res_hi;
  logic [31:0] r_res_lo;
  logic        r_dz;
  logic        r_busy;
  logic        r_done;

  mdu_op_e     w_op;
  logic [63:0] w_res;
  logic        w_dz;
  logic        w_is_mul;
  logic        w_is_div;
  logic        w_start;
  logic        w_mthi;
  logic        w_mtlo;
  logic        w_commit;

  assign w_op     = mdu_op_e'(mduOp);
  assign w_is_mul = (w_op == MDU_MULT) ||
                    (w_op == MDU_MULTU);
  assign w_is_div = (w_op == MDU_DIV) ||
                    (w_op == MDU_DIVU);

  mdu_arith u_arith (
    .i_op  (w_op),
    .i_a   (mduA),
    .i_b   (mduB),
    .o_res (w_res),
    .o_dz  (w_dz)
  );

  // next-state, counter and write-enable decode
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_start     = 1'b0;
    w_mthi      = 1'b0;
    w_mtlo      = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mduStart) begin
          unique case (1'b1)
            w_is_mul: begin
              w_start     = 1'b1;
              w_cnt_nxt   = CW'(MULT_CYCLES);
              w_state_nxt = ST_BUSY;
            end
            w_is_div: begin
              w_start     = 1'b1;
              w_cnt_nxt   = CW'(DIV_CYCLES);
              w_state_nxt = ST_BUSY;
            end
            (w_op == MDU_MTHI): w_mthi = 1'b1;
            (w_op == MDU_MTLO): w_mtlo = 1'b1;
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_commit    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // state, shadow result and HI/LO registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= 32'h0;
      r_lo     <= 32'h0;
      r_res_hi <= 32'h0;
      r_res_lo <= 32'h0;
      r_dz     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt == ST_BUSY);
      r_done  <= w_commit;
      if (w_start) begin
        r_res_hi <= w_res[63:32];
        r_res_lo <= w_res[31:0];
        r_dz     <= w_dz;
      end
      if (w_commit && !r_dz) begin
        r_hi <= r_res_hi;
        r_lo <= r_res_lo;
      end
      if (w_mthi) r_hi <= mduA;
      if (w_mtlo) r_lo <= mduA;
    end
  end

`ifdef MDU_DISPLAY_EN
  logic [31:0] r_pc;

  // remember the issuing pc for the later commit print
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc <= 32'h0;
    end else if (w_start) begin
      r_pc <= pc;
    end
  end

  // trace every HI/LO write
  always_ff @(posedge clk) begin
    if (reset) begin
      if (w_commit && !r_dz) begin
        $display("@%h: HI <= %h", r_pc, r_res_hi);
        $display("@%h: LO <= %h", r_pc, r_res_lo);
      end
      if (w_mthi) $display("@%h: HI <= %h", pc, mduA);
      if (w_mtlo) $display("@%h: LO <= %h", pc, mduA);
    end
  end
`else
  logic w_unused_pc;
  assign w_unused_pc = ^pc;
`endif

  assign mduRD   = mduReadHi ? r_hi : r_lo;
  assign mduBusy = r_busy;
  assign mduDone = r_done;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit.
// Expected commits are queued at issue and checked on mduDone.
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int NM = 5;
  localparam int ND = 10;

  logic        clk;
  logic        reset;
  logic        mduStart;
  logic [2:0]  mduOp;
  logic [31:0] mduA;
  logic [31:0] mduB;
  logic        mduReadHi;
  logic [31:0] mduRD;
  logic        mduBusy;
  logic        mduDone;
  logic [31:0] pc;

  int n_chk  = 0;
  int n_fail = 0;
  logic [63:0] sb_q[$];
  logic [31:0] mon_h;
  logic [31:0] mon_l;
  logic [63:0] mon_e;
  logic [31:0] st_h;
  logic [31:0] st_l;

  mult_div_unit #(
    .MULT_CYCLES (NM),
    .DIV_CYCLES  (ND)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mduStart  (mduStart),
    .mduOp     (mduOp),
    .mduA      (mduA),
    .mduB      (mduB),
    .mduReadHi (mduReadHi),
    .mduRD     (mduRD),
    .mduBusy   (mduBusy),
    .mduDone   (mduDone),
    .pc        (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic read_hl(output logic [31:0] hi,
                         output logic [31:0] lo);
    mduReadHi = 1'b1;
    #1 hi = mduRD;
    mduReadHi = 1'b0;
    #1 lo = mduRD;
  endtask

  // monitor: every done pulse must match the oldest queued commit
  always @(negedge clk) begin
    if (mduDone === 1'b1) begin
      read_hl(mon_h, mon_l);
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected none");
      end else begin
        mon_e = sb_q.pop_front();
        chk("commit_hi", mon_h, mon_e[63:32]);
        chk("commit_lo", mon_l, mon_e[31:0]);
      end
    end
  end

  // drive one op at a negedge; sampled at the next posedge
  task automatic issue(input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    mduStart = 1'b1;
    mduOp    = op;
    mduA     = a;
    mduB     = b;
    @(posedge clk);
    #1;
    mduStart = 1'b0;
    mduOp    = 3'd0;
  endtask

  // count busy cycles until done; pre = cycles already seen
  task automatic wait_busy(input string name,
                           input int pre,
                           input int n);
    int c;
    c = pre;
    @(negedge clk);
    while (mduBusy === 1'b1 && c < 200) begin
      c++;
      @(negedge clk);
    end
    chk({name, "_busy_cycles"}, 32'(c), 32'(n));
    chk({name, "_busy_low"}, 32'(mduBusy), 32'd0);
    chk({name, "_done"}, 32'(mduDone), 32'd1);
  endtask

  task automatic run(input string name,
                     input logic [2:0] op,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input int n,
                     input logic [31:0] eh,
                     input logic [31:0] el);
    sb_q.push_back({eh, el});
    issue(op, a, b);
    wait_busy(name, 0, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    mduStart  = 1'b0;
    mduOp     = 3'd0;
    mduA      = 32'h0;
    mduB      = 32'h0;
    mduReadHi = 1'b0;
    pc        = 32'h0040_0000;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(mduBusy), 32'd0);
    chk("rst_done", 32'(mduDone), 32'd0);
    read_hl(st_h, st_l);
    chk("rst_hi", st_h, 32'h0);
    chk("rst_lo", st_l, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    run("mult", MDU_MULT, 32'hFFFF_FFFE, 32'd3, NM,
        32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'd2, NM,
        32'h0000_0001, 32'hFFFF_FFFE);
    run("div", MDU_DIV, 32'hFFFF_FFF9, 32'd2, ND,
        32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("divu_dz", MDU_DIVU, 32'd7, 32'd0, ND,
        32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("div_ovf", MDU_DIV, 32'h8000_0000,
        32'hFFFF_FFFF, ND,
        32'h0000_0000, 32'h8000_0000);
    run("mult_b2b", MDU_MULT, 32'hFFFF_FFFA, 32'd7, NM,
        32'hFFFF_FFFF, 32'hFFFF_FFD6);
    run("divu", MDU_DIVU, 32'd100, 32'd7, ND,
        32'd2, 32'd14);

    // MTHI during an in-flight MULT must be ignored
    sb_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFD0});
    issue(MDU_MULT, 32'hFFFF_FFFD, 32'h10);
    repeat (3) @(negedge clk);
    issue(MDU_MTHI, 32'h1234_5678, 32'h0);
    wait_busy("mult_mthi", 3, NM);

    // MTLO while idle
    issue(MDU_MTLO, 32'hCAFE_BABE, 32'h0);
    @(negedge clk);
    chk("mtlo_busy", 32'(mduBusy), 32'd0);
    read_hl(st_h, st_l);
    chk("mtlo_lo", st_l, 32'hCAFE_BABE);
    chk("mtlo_hi", st_h, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("mtlo_busy2", 32'(mduBusy), 32'd0);
    chk("mtlo_done", 32'(mduDone), 32'd0);

    // reset aborts an in-flight DIV, beating a new start
    issue(MDU_DIV, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    reset    = 1'b0;
    mduStart = 1'b1;
    mduOp    = MDU_MULT;
    mduA     = 32'd5;
    mduB     = 32'd5;
    @(posedge clk);
    #1;
    mduStart = 1'b0;
    mduOp    = 3'd0;
    @(negedge clk);
    chk("abort_busy", 32'(mduBusy), 32'd0);
    chk("abort_done", 32'(mduDone), 32'd0);
    read_hl(st_h, st_l);
    chk("abort_hi", st_h, 32'h0);
    chk("abort_lo", st_l, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    run("post_rst", MDU_MULTU, 32'h0001_0000,
        32'h0001_0000, NM, 32'd1, 32'd0);

    repeat (4) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
